// File: rtl/sdram_req_responder.sv
// Block-RAM stand-in for the SDRAM driver side of the reader/writer/resp request interface.
// Optional request/beat counters are enabled with `define SDRAM_REQ_RESPONDER_STATS_EN.
module sdram_req_responder #(
  parameter int ADDR_W       = 12,
  parameter int BURST_LEN    = 8,
  parameter int READ_LATENCY = 3
) (
  input  logic        clk_axi,
  input  logic        rst_axi,
  input  logic        reader_valid,
  output logic        reader_ready,
  input  logic [23:0] reader_addr,
  input  logic        writer_valid,
  output logic        writer_ready,
  input  logic [23:0] writer_addr,
  input  logic [15:0] writer_data,
  output logic        resp_valid,
  output logic        resp_last,
  output logic [15:0] resp_data,
  input  logic        resp_ready,
`ifdef SDRAM_REQ_RESPONDER_STATS_EN
  output logic [15:0] rd_req_cnt_o,
  output logic [15:0] wr_req_cnt_o,
  output logic [15:0] beat_cnt_o,
`endif
  output logic        busy_o
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [BCNT_W-1:0]   beat_q, beat_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_last_q, resp_last_d;
  logic [15:0]         resp_data_q;
  logic                rd_en, wr_en;
  logic [15:0]         mem [DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{reader_addr[23:ADDR_W], writer_addr[23:ADDR_W]};

  // Ready only in IDLE and never while reset is asserted; a pending write blocks the read.
  assign writer_ready = (state_q == ST_IDLE) && !rst_axi;
  assign reader_ready = writer_ready && !writer_valid;
  assign busy_o       = (state_q != ST_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_last    = resp_last_q;
  assign resp_data    = resp_data_q;

  // addr_q always holds the address of the next beat to fetch; beat_q counts beats fetched.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lat_d        = lat_q;
    beat_d       = beat_q;
    resp_valid_d = resp_valid_q;
    resp_last_d  = resp_last_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (writer_valid) begin
          wr_en = !rst_axi;
        end else if (reader_valid) begin
          addr_d  = reader_addr[ADDR_W-1:0];
          lat_d   = LAT_W'(READ_LATENCY - 1);
          beat_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          rd_en        = 1'b1;
          addr_d       = addr_q + ADDR_W'(1);
          beat_d       = BCNT_W'(1);
          resp_valid_d = 1'b1;
          resp_last_d  = (BURST_LEN == 1);
          state_d      = ST_BURST;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_BURST: begin
        if (resp_valid_q && resp_ready && resp_last_q) begin
          resp_valid_d = 1'b0;
          resp_last_d  = 1'b0;
          state_d      = ST_IDLE;
        end else if ((!resp_valid_q || resp_ready) && (beat_q < BCNT_W'(BURST_LEN))) begin
          rd_en        = 1'b1;
          addr_d       = addr_q + ADDR_W'(1);
          beat_d       = beat_q + BCNT_W'(1);
          resp_valid_d = 1'b1;
          resp_last_d  = (beat_q == BCNT_W'(BURST_LEN - 1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_axi) begin
    if (rst_axi) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      lat_q        <= '0;
      beat_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lat_q        <= lat_d;
      beat_q       <= beat_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_axi) begin
    if (wr_en) mem[writer_addr[ADDR_W-1:0]] <= writer_data;
  end

  // Synchronous read port doubling as the resp output register.
  always_ff @(posedge clk_axi) begin
    if (rst_axi)    resp_data_q <= '0;
    else if (rd_en) resp_data_q <= mem[addr_q];
  end

`ifdef SDRAM_REQ_RESPONDER_STATS_EN
  logic [15:0] rd_req_cnt_q, rd_req_cnt_d;
  logic [15:0] wr_req_cnt_q, wr_req_cnt_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    rd_req_cnt_d = rd_req_cnt_q + 16'(reader_valid && reader_ready);
    wr_req_cnt_d = wr_req_cnt_q + 16'(writer_valid && writer_ready);
    beat_cnt_d   = beat_cnt_q + 16'(resp_valid_q && resp_ready);
  end

  always_ff @(posedge clk_axi) begin
    if (rst_axi) begin
      rd_req_cnt_q <= '0;
      wr_req_cnt_q <= '0;
      beat_cnt_q   <= '0;
    end else begin
      rd_req_cnt_q <= rd_req_cnt_d;
      wr_req_cnt_q <= wr_req_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign rd_req_cnt_o = rd_req_cnt_q;
  assign wr_req_cnt_o = wr_req_cnt_q;
  assign beat_cnt_o   = beat_cnt_q;
`endif

endmodule

// File: doc/sdram_req_responder.md
Name: sdram_req_responder

Overview:
- Single-clock responder for the reader/writer/resp request interface, i.e. the SDRAM-driver side of that interface, backed by on-chip block RAM instead of external SDRAM.
- Accepts single-word writes and burst-read requests, and returns burst data on the resp stream with resp_last on the final beat.
- Stands in for the SDRAM driver so the memory tester and other request initiators can be brought up and regressed without an SDRAM model.
- Adds a programmable read latency to emulate the SDRAM CAS/row delay.

Parameters:
- ADDR_W, 12, number of RAM address bits; depth = 2**ADDR_W 16-bit words; upper request address bits are ignored.
- BURST_LEN, 8, beats returned per read request (1..256).
- READ_LATENCY, 3, cycles from read-request accept to first resp beat (1..15).

Ports:
- clk_axi  in  1  sole clock.
- rst_axi  in  1  synchronous, active-high reset.
- reader_valid  in  1  read request valid.
- reader_ready  out  1  read request accepted when valid&&ready.
- reader_addr  in  24  burst start word address.
- writer_valid  in  1  write request valid.
- writer_ready  out  1  write accepted when valid&&ready.
- writer_addr  in  24  write word address.
- writer_data  in  16  write data.
- resp_valid  out  1  read beat valid.
- resp_last  out  1  final beat of burst; qualified by resp_valid.
- resp_data  out  16  read beat data.
- resp_ready  in  1  consumer accepts beat.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset is synchronous and active-high on rst_axi, with one clock clk_axi.
- Reset values: reader_ready=0, writer_ready=0, resp_valid=0, resp_last=0, resp_data=0, busy_o=0, state=IDLE.
- RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, BURST.
- IDLE:
  - reader_ready=1 and writer_ready=1, combinationally, only in IDLE.
  - If writer_valid is high: write mem[writer_addr[ADDR_W-1:0]] <= writer_data that cycle; stay in IDLE. Write wins when both requests are valid; the read stays pending, so reader_ready=0 that cycle.
  - Else if reader_valid is high: capture addr[ADDR_W-1:0], load lat_cnt=READ_LATENCY-1 and beat_cnt=0, then go to WAIT.
- WAIT:
  - Decrement lat_cnt each cycle.
  - On the cycle lat_cnt==0, issue the RAM read of the start address and go to BURST.
  - First resp_valid rises exactly READ_LATENCY cycles after the accept edge.
- BURST:
  - Output register loads mem[addr + beat index] whenever !resp_valid || resp_ready.
  - Read address advances only when a beat is accepted or the output register is empty.
  - Full throughput is 1 beat/cycle with resp_ready held at 1.
  - Address increment is modulo 2**ADDR_W (wraps from depth-1 to 0).
  - resp_last=1 on beat BURST_LEN-1 only.
  - On acceptance of the last beat (resp_valid&&resp_ready&&resp_last): resp_valid deasserts next cycle, state goes to IDLE, and new requests are accepted the cycle after.
- Backpressure: while resp_valid && !resp_ready, resp_data, resp_last and resp_valid hold stable. No beat is dropped or duplicated.
- Requests arriving outside IDLE: ready stays 0 and the initiator must hold valid; no queueing.
- Reset mid-burst: the next cycle is IDLE with resp_valid=0 and the remaining beats discarded; RAM is unchanged.
- Read-during-write hazard: cannot occur, because writes are accepted only in IDLE.

Optional Feature:
- Macro: SDRAM_REQ_RESPONDER_STATS_EN.
- When defined:
  - Adds output ports rd_req_cnt_o[15:0], wr_req_cnt_o[15:0] and beat_cnt_o[15:0].
  - These count accepted read requests, accepted writes and accepted resp beats.
  - Each counter wraps at 16 bits and is cleared by rst_axi.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Write 0xA000..0xA007 to addr 0x10..0x17, then read 0x10 with BURST_LEN=8, READ_LATENCY=3, resp_ready=1 -> first beat 3 cycles after accept, 8 consecutive beats 0xA000..0xA007, resp_last only on 0xA007, busy_o low the cycle after.
- Same read with resp_ready toggled 1/0 every cycle -> data held stable during stalls, beat sequence identical, 8 beats total, no duplicates.
- reader_valid and writer_valid high together in IDLE (write 0x1234 to 0x20, read 0x20) -> write accepted first, read accepted next cycle, first beat=0x1234.
- Read at addr 0xFFE with ADDR_W=12 -> beats from 0xFFE, 0xFFF, then 0x000... (wrap), resp_last on beat 8.
- rst_axi asserted for one cycle during beat 3 -> resp_valid=0 next cycle; new read of 0x10 after reset returns the pre-reset RAM data 0xA000...
- With SDRAM_REQ_RESPONDER_STATS_EN defined after the first scenario -> rd_req_cnt_o=1, wr_req_cnt_o=8, beat_cnt_o=8.
